// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage and its register file.
package wb_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Writeback data selects; the controller drives wd_sel with these codes.
  localparam logic [1:0] WD_SEL_ALU = 2'b00;
  localparam logic [1:0] WD_SEL_MEM = 2'b01;
  localparam logic [1:0] WD_SEL_PC4 = 2'b10;

endpackage

// File: rtl/wb_regfile_2r1w.sv
// 32-entry register file: one write port, two bypassed read ports for ID,
// and one raw debug read port. x0 is hard-wired to zero.
module wb_regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0]     rdata1_o,
  output logic [DATA_W-1:0]     rdata2_o,
  input  logic [REG_ADDR_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0]     dbg_rdata_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Register array: async clear; x0 is never written so it stays zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: x0 reads zero, same-cycle write is forwarded.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (we_i && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (we_i && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end
  end

  // Debug port shows the stored state only, so a write appears a cycle later.
  assign dbg_rdata_o = regs_q[dbg_raddr_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the register
// file, and keeps a one-cycle-delayed commit trace plus a retire counter.
// valid_i is a qualifier only (no ready): each cycle it is high retires one
// instruction, so a stalled MEM/WB must present bubbles on repeat cycles.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [XLEN-1:0]       current_pc_i,
  input  logic [XLEN-1:0]       return_pc_i,
  input  logic [DATA_W-1:0]     alu_result_i,
  input  logic [DATA_W-1:0]     mem_rd_i,
  input  logic [REG_ADDR_W-1:0] wr_i,
  input  logic [1:0]            wd_sel_i,
  input  logic                  regfile_we_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic [DATA_W-1:0]     rd1_o,
  output logic [DATA_W-1:0]     rd2_o,
  input  logic [REG_ADDR_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0]     dbg_rdata_o,
  output logic                  commit_o,
  output logic [XLEN-1:0]       commit_pc_o,
  output logic [REG_ADDR_W-1:0] commit_wr_o,
  output logic [DATA_W-1:0]     commit_wd_o,
  output logic [CNT_W-1:0]      instret_o
);

  logic [DATA_W-1:0]     wd;
  logic                  we_eff;

  logic                  commit_q;
  logic [XLEN-1:0]       commit_pc_q, commit_pc_d;
  logic [REG_ADDR_W-1:0] commit_wr_q, commit_wr_d;
  logic [DATA_W-1:0]     commit_wd_q, commit_wd_d;
  logic [CNT_W-1:0]      instret_q;

  // Writeback data select; the unused code 2'b11 falls back to the ALU.
  always_comb begin
    wd = alu_result_i;
    case (wd_sel_i)
      WD_SEL_MEM: wd = mem_rd_i;
      WD_SEL_PC4: wd = return_pc_i[DATA_W-1:0];
      default:    wd = alu_result_i;
    endcase
  end

  assign we_eff = valid_i & regfile_we_i & (wr_i != '0);

  wb_regfile_2r1w #(.DATA_W(DATA_W)) u_rf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .we_i        (we_eff),
    .waddr_i     (wr_i),
    .wdata_i     (wd),
    .raddr1_i    (rs1_i),
    .raddr2_i    (rs2_i),
    .rdata1_o    (rd1_o),
    .rdata2_o    (rd2_o),
    .dbg_raddr_i (dbg_raddr_i),
    .dbg_rdata_o (dbg_rdata_o)
  );

  // Next trace values: non-writing retires record rd/data as zero.
  always_comb begin
    commit_pc_d = current_pc_i;
    commit_wr_d = we_eff ? wr_i : '0;
    commit_wd_d = we_eff ? wd   : '0;
  end

  // Commit trace: pulse every cycle, payload only updates on a retire.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commit_q    <= 1'b0;
      commit_pc_q <= '0;
      commit_wr_q <= '0;
      commit_wd_q <= '0;
    end else begin
      commit_q <= valid_i;
      if (valid_i) begin
        commit_pc_q <= commit_pc_d;
        commit_wr_q <= commit_wr_d;
        commit_wd_q <= commit_wd_d;
      end
    end
  end

  // Retired-instruction counter, wraps freely.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instret_q <= '0;
    end else if (valid_i) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign commit_o    = commit_q;
  assign commit_pc_o = commit_pc_q;
  assign commit_wr_o = commit_wr_q;
  assign commit_wd_o = commit_wd_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile, built with a 4-bit retire counter so wrap is reachable.
module tb_wb_regfile;

  localparam int CW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] current_pc_i, return_pc_i, alu_result_i, mem_rd_i;
  logic [4:0]  wr_i, rs1_i, rs2_i, dbg_raddr_i;
  logic [1:0]  wd_sel_i;
  logic        regfile_we_i;
  logic [31:0] rd1_o, rd2_o, dbg_rdata_o;
  logic        commit_o;
  logic [31:0] commit_pc_o, commit_wd_o;
  logic [4:0]  commit_wr_o;
  logic [CW-1:0] instret_o;

  always #5 clk_i = ~clk_i;

  wb_regfile #(.DATA_W(32), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .current_pc_i(current_pc_i), .return_pc_i(return_pc_i),
    .alu_result_i(alu_result_i), .mem_rd_i(mem_rd_i), .wr_i(wr_i),
    .wd_sel_i(wd_sel_i), .regfile_we_i(regfile_we_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd1_o(rd1_o), .rd2_o(rd2_o),
    .dbg_raddr_i(dbg_raddr_i), .dbg_rdata_o(dbg_rdata_o),
    .commit_o(commit_o), .commit_pc_o(commit_pc_o), .commit_wr_o(commit_wr_o),
    .commit_wd_o(commit_wd_o), .instret_o(instret_o)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic        m_commit;
  logic [31:0] m_pc, m_wd;
  logic [4:0]  m_wr;
  int unsigned m_retired;   // total retires since reset; counter = this mod 2^CW

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] m_wdata();
    if (wd_sel_i == 2'd1) return mem_rd_i;
    if (wd_sel_i == 2'd2) return return_pc_i;
    return alu_result_i;
  endfunction

  function automatic logic m_writes();
    return valid_i && regfile_we_i && (wr_i != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_writes() && a == wr_i) return m_wdata();
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_commit = 1'b0; m_pc = 32'd0; m_wr = 5'd0; m_wd = 32'd0; m_retired = 0;
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic v, input logic we, input logic [4:0] wr,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc4,
                        input logic [31:0] pc);
    valid_i = v; regfile_we_i = we; wr_i = wr; wd_sel_i = sel;
    alu_result_i = alu; mem_rd_i = mem; return_pc_i = pc4; current_pc_i = pc;
  endtask

  // One WB cycle: check combinational reads, clock, then check the trace.
  task automatic step();
    logic        w;
    logic [31:0] d;
    #1;
    check("rd1", rd1_o, m_read(rs1_i));
    check("rd2", rd2_o, m_read(rs2_i));
    check("dbg", dbg_rdata_o, m_regs[dbg_raddr_i]);
    w = m_writes();
    d = m_wdata();
    @(posedge clk_i);
    if (w) m_regs[wr_i] = d;
    m_commit = valid_i;
    if (valid_i) begin
      m_pc = current_pc_i;
      m_wr = w ? wr_i : 5'd0;
      m_wd = w ? d : 32'd0;
      m_retired++;
    end
    #1;
    check("commit", {31'd0, commit_o}, {31'd0, m_commit});
    check("commit_pc", commit_pc_o, m_pc);
    check("commit_wr", {27'd0, commit_wr_o}, {27'd0, m_wr});
    check("commit_wd", commit_wd_o, m_wd);
    check("instret", {28'd0, instret_o}, m_retired % (1 << CW));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  wr;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  dbg_a;
    logic [31:0] exp_rd1;   // same-cycle rd1
    logic [31:0] exp_dbg;   // dbg at dbg_a after the edge
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd3, 2'b00, 32'hA, 32'hB, 32'h104, 32'h100, 5'd3, 5'd3, 32'hA,   32'hA};
    vecs[1] = '{1'b1, 1'b1, 5'd3, 2'b01, 32'hA, 32'hB, 32'h104, 32'h104, 5'd3, 5'd3, 32'hB,   32'hB};
    vecs[2] = '{1'b1, 1'b1, 5'd3, 2'b10, 32'hA, 32'hB, 32'h104, 32'h108, 5'd3, 5'd3, 32'h104, 32'h104};
    vecs[3] = '{1'b1, 1'b1, 5'd3, 2'b11, 32'hA, 32'hB, 32'h104, 32'h10C, 5'd3, 5'd3, 32'hA,   32'hA};
    // x0 guard: write to x0 is dropped, x3 keeps 0xA
    vecs[4] = '{1'b1, 1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h110, 5'd0, 5'd3, 32'h0, 32'hA};
    // bubble with write enable: x4 stays 0
    vecs[5] = '{1'b0, 1'b1, 5'd4, 2'b00, 32'h55, 32'h0, 32'h0, 32'h200, 5'd4, 5'd4, 32'h0, 32'h0};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_i = 1'b1;
    set_in(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    rs1_i = 5'd0; rs2_i = 5'd0; dbg_raddr_i = 5'd0;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_commit", {31'd0, commit_o}, 32'd0);
    check("reset_instret", {28'd0, instret_o}, 32'd0);
    rst_i = 1'b0;

    // table vectors
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].v, vecs[i].we, vecs[i].wr, vecs[i].sel, vecs[i].alu,
             vecs[i].mem, vecs[i].pc4, vecs[i].pc);
      rs1_i = vecs[i].rs1; rs2_i = vecs[i].rs1; dbg_raddr_i = vecs[i].dbg_a;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1_o, vecs[i].exp_rd1);
      step();
      check($sformatf("vec%0d_dbg", i), dbg_rdata_o, vecs[i].exp_dbg);
    end
    // after the bubble: 5 retires so far, trace still shows the x0 instruction
    check("bubble_instret", {28'd0, instret_o}, 32'd5);
    check("bubble_commit_pc", commit_pc_o, 32'h110);

    // bypass: x7 = 0x11, then write x7 = 0x22 while ID reads x7 on both ports
    set_in(1'b1, 1'b1, 5'd7, 2'b00, 32'h11, 32'h0, 32'h0, 32'h300);
    rs1_i = 5'd0; rs2_i = 5'd0; dbg_raddr_i = 5'd7;
    step();
    set_in(1'b1, 1'b1, 5'd7, 2'b00, 32'h22, 32'h0, 32'h0, 32'h304);
    rs1_i = 5'd7; rs2_i = 5'd7;
    #1;
    check("byp_rd1", rd1_o, 32'h22);
    check("byp_rd2", rd2_o, 32'h22);
    check("byp_dbg_old", dbg_rdata_o, 32'h11);
    step();
    check("byp_dbg_new", dbg_rdata_o, 32'h22);

    // reset mid-run: x5 = 0x1234, then reset while a write to x6 is pending
    set_in(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234, 32'h0, 32'h0, 32'h400);
    step();
    set_in(1'b1, 1'b1, 5'd6, 2'b00, 32'h5678, 32'h0, 32'h0, 32'h404);
    #2;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    set_in(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    rs1_i = 5'd5; rs2_i = 5'd6; dbg_raddr_i = 5'd5;
    #1;
    check("rst_rd1", rd1_o, 32'd0);
    check("rst_rd2", rd2_o, 32'd0);
    check("rst_dbg", dbg_rdata_o, 32'd0);
    dbg_raddr_i = 5'd6;
    #1;
    check("rst_dbg6", dbg_rdata_o, 32'd0);
    check("rst_commit", {31'd0, commit_o}, 32'd0);
    check("rst_commit_pc", commit_pc_o, 32'd0);
    check("rst_commit_wr", {27'd0, commit_wr_o}, 32'd0);
    check("rst_commit_wd", commit_wd_o, 32'd0);
    check("rst_instret", {28'd0, instret_o}, 32'd0);
    rst_i = 1'b0;
    m_reset();

    // counter wrap: 17 retires on a 4-bit counter, last PC 0x40
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 32'(i * 4));
      rs1_i = 5'($urandom_range(0, 31)); rs2_i = 5'($urandom_range(0, 31));
      dbg_raddr_i = 5'($urandom_range(0, 31));
      step();
    end
    check("wrap_instret", {28'd0, instret_o}, 32'd1);
    check("wrap_commit_pc", commit_pc_o, 32'h40);

    // randomized traffic against the model; small address range to hit bypasses
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom, $urandom);
      rs1_i = 5'($urandom_range(0, 7)); rs2_i = 5'($urandom_range(0, 7));
      dbg_raddr_i = 5'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register in the stalled 5-stage pipeline.
- Selects the writeback data (ALU result, load data or return PC) and commits it to a 32x32 integer register file.
- Provides two bypassed read ports for ID, plus one debug read port for board display.
- Keeps a registered commit trace and a retired-instruction counter.

Parameters:
DATA_W, 32, register/data width.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-high.
valid_i  in  1  WB slot holds a real instruction (0 = bubble/flush).
current_pc_i  in  32  PC of WB instruction.
return_pc_i  in  32  PC+4 of WB instruction.
alu_result_i  in  32  ALU result.
mem_rd_i  in  32  load data.
wr_i  in  5  destination register.
wd_sel_i  in  2  writeback select.
regfile_we_i  in  1  register write enable.
rs1_i  in  5  ID read address 1.
rs2_i  in  5  ID read address 2.
rd1_o  out  32  read data 1 (combinational).
rd2_o  out  32  read data 2 (combinational).
dbg_raddr_i  in  5  debug read address.
dbg_rdata_o  out  32  debug read data (combinational, no bypass).
commit_o  out  1  registered pulse: an instruction retired last cycle.
commit_pc_o  out  32  PC of last retired instruction.
commit_wr_o  out  5  rd of last retired write (0 if none).
commit_wd_o  out  32  data of last retired write (0 if none).
instret_o  out  CNT_W  retired-instruction count.

Behaviour:
Writeback data select (combinational):
- wd_sel 2'b00 = alu_result_i; 2'b01 = mem_rd_i; 2'b10 = return_pc_i; 2'b11 = alu_result_i.

Register file:
- Write qualifier: we_eff = valid_i & regfile_we_i & (wr_i != 0).
- On posedge clk_i with we_eff, regs[wr_i] <= wd.
- x0 is never written and always reads 0.
- rst_i asynchronously clears all 32 registers to 0. Reset mid-operation discards any pending write that cycle.

Read ports (rd1_o/rd2_o):
- Address 0 returns 0.
- If the address equals wr_i and we_eff, return wd (same-cycle write-through bypass, so ID sees the WB value without an extra stall).
- Otherwise return regs[addr].
- rs1 == rs2 is legal; both ports return the same value.
- dbg_rdata_o returns regs[dbg_raddr_i] with no bypass; it shows the new value one cycle after the write.

Commit trace (registered, 1-cycle latency after the WB cycle):
- commit_o <= valid_i. A bubble gives commit_o = 0 and leaves the other trace outputs holding their previous values.
- On valid_i:
  - commit_pc_o <= current_pc_i.
  - commit_wr_o <= we_eff ? wr_i : 0.
  - commit_wd_o <= we_eff ? wd : 0.
- Reset value of all trace outputs is 0.

Retired-instruction counter:
- instret_o increments by 1 on each clock edge with valid_i = 1, including non-writing instructions (stores, branches).
- Wraps modulo 2^CNT_W with no saturation.
- Reset value is 0.

Stall interaction:
- The block has no stall input. MEM/WB holds or injects a bubble (valid_i = 0) during a stall.
- A held valid instruction is counted once per cycle it is presented, so the pipeline must deassert valid_i on repeat cycles.

Decomposition:
- Shared package: WD_SEL_ALU = 2'b00, WD_SEL_MEM = 2'b01, WD_SEL_PC4 = 2'b10 (same constants the controller uses to drive wd_sel), REG_ADDR_W = 5, XLEN = 32.
- One natural sub-module: regfile_2r1w, holding the 32x32 array with async reset, the x0 rule, two bypassed read ports and the debug port.
- The wd mux, commit trace and counter stay in the top module.

Test Plan:
- Reset: assert rst_i mid-run after writing x5 = 0x1234 -> all rd/dbg reads return 0, instret_o = 0, commit_o = 0, all commit_* = 0.
- Select: wr = 3, we = 1, valid = 1, cycling wd_sel 00/01/10 with alu = 0xA, mem = 0xB, pc4 = 0x104 -> dbg x3 reads 0xA, then 0xB, then 0x104 on successive cycles; wd_sel 11 writes 0xA.
- x0 guard: wr = 0, we = 1, alu = 0xFFFF_FFFF -> rd1 (rs1 = 0) = 0; commit_wr_o = 0 and commit_wd_o = 0; instret_o increments by 1.
- Bypass: regs x7 = 0x11, WB writes x7 = 0x22 with rs1 = rs2 = 7 -> rd1 = rd2 = 0x22 in the same cycle, dbg x7 = 0x11 that cycle and 0x22 the next.
- Bubble: valid_i = 0 with we = 1, wr = 4, alu = 0x55 -> x4 unchanged, commit_o = 0, instret_o unchanged, commit_pc_o holds its previous value.
- Counter wrap: CNT_W = 4, 17 valid cycles -> instret_o = 1; commit_pc_o tracks the last current_pc_i, e.g. 0x0000_0040.
